// File: rtl/beat_period_counter.sv
// Beat period counter: times NUM_EDGES periods of the sampled beat signal in CLK cycles.
// Optional macro BEAT_GLITCH_FILTER_EN requires two high samples to qualify an edge.
module beat_period_counter #(
    parameter int CNT_W     = 16,
    parameter int NUM_EDGES = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic [0:2]       SAMPLE_IN,
    output logic [CNT_W-1:0] COUNT_OUT,
    output logic             VALID,
    input  logic             ACK,
    output logic             BUSY,
    output logic             OVERFLOW
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       LAST_EDGE = 8'(NUM_EDGES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [7:0]       edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] count_out_q, count_out_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             edge_s;
    logic             final_edge_s;
    logic             cnt_at_max_s;

`ifdef BEAT_GLITCH_FILTER_EN
    assign edge_s = SAMPLE_IN[0] & SAMPLE_IN[1] & ~SAMPLE_IN[2];
`else
    logic unused_s;
    assign unused_s = SAMPLE_IN[0];
    assign edge_s   = SAMPLE_IN[1] & ~SAMPLE_IN[2];
`endif

    assign final_edge_s = edge_s && (edge_cnt_q == LAST_EDGE);
    assign cnt_at_max_s = (cyc_cnt_q == CNT_MAX);

    // State and datapath registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            cyc_cnt_q   <= CNT_ZERO;
            edge_cnt_q  <= 8'd0;
            count_out_q <= CNT_ZERO;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_cnt_q   <= cyc_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            count_out_q <= count_out_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_ARM;
                else       state_d = S_IDLE;
            end
            S_ARM: begin
                if (edge_s) state_d = S_COUNT;
                else        state_d = S_ARM;
            end
            S_COUNT: begin
                if (final_edge_s || cnt_at_max_s) state_d = S_DONE;
                else                              state_d = S_COUNT;
            end
            S_DONE: begin
                if (ACK) state_d = S_IDLE;
                else     state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters and result capture; a final edge takes priority over saturation
    always_comb begin
        cyc_cnt_d   = cyc_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        count_out_d = count_out_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_ARM: begin
                if (edge_s) begin
                    cyc_cnt_d  = CNT_ZERO;
                    edge_cnt_d = 8'd0;
                end else begin
                    cyc_cnt_d  = cyc_cnt_q;
                end
            end
            S_COUNT: begin
                if (cnt_at_max_s) cyc_cnt_d = cyc_cnt_q;
                else              cyc_cnt_d = cyc_cnt_q + CNT_ONE;
                if (edge_s) edge_cnt_d = edge_cnt_q + 8'd1;
                else        edge_cnt_d = edge_cnt_q;
                if (final_edge_s) begin
                    count_out_d = cnt_at_max_s ? CNT_MAX : (cyc_cnt_q + CNT_ONE);
                    ovf_d       = 1'b0;
                end else if (cnt_at_max_s) begin
                    count_out_d = CNT_MAX;
                    ovf_d       = 1'b1;
                end else begin
                    count_out_d = count_out_q;
                end
            end
            default: begin
                cyc_cnt_d = cyc_cnt_q;
            end
        endcase
    end

    // Status outputs decoded from the upcoming state so they are registered
    always_comb begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        case (state_d)
            S_ARM, S_COUNT: busy_d  = 1'b1;
            S_DONE:         valid_d = 1'b1;
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign COUNT_OUT = count_out_q;
    assign OVERFLOW  = ovf_q;
    assign VALID     = valid_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_beat_period_counter.sv
// Bench for beat_period_counter: four instances with different CNT_W / NUM_EDGES,
// table-driven measurements with a result scoreboard plus hand-written corner sequences.
module tb_beat_period_counter;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [3:0] start_i, ack_i, valid_o, busy_o, ovf_o;
    logic [0:2] hist [4];
    logic [15:0] c0, c1, c3;
    logic [3:0]  c2;

    int per [4];
    int ph  [4];
    int gpos[4];
    logic [3:0] gl_en;

    int errors = 0;
    int checks = 0;

    typedef struct { int inst; logic [15:0] cnt; logic ovf; } exp_t;
    typedef struct { int inst; int period; logic [15:0] cnt; logic ovf; } vec_t;
    exp_t sb[$];
    vec_t vecs[8];

    always #5 CLK = ~CLK;

    beat_period_counter #(.CNT_W(16), .NUM_EDGES(4)) u0 (
        .CLK(CLK), .RSTN(RSTN), .START(start_i[0]), .SAMPLE_IN(hist[0]), .COUNT_OUT(c0),
        .VALID(valid_o[0]), .ACK(ack_i[0]), .BUSY(busy_o[0]), .OVERFLOW(ovf_o[0]));
    beat_period_counter #(.CNT_W(16), .NUM_EDGES(1)) u1 (
        .CLK(CLK), .RSTN(RSTN), .START(start_i[1]), .SAMPLE_IN(hist[1]), .COUNT_OUT(c1),
        .VALID(valid_o[1]), .ACK(ack_i[1]), .BUSY(busy_o[1]), .OVERFLOW(ovf_o[1]));
    beat_period_counter #(.CNT_W(4), .NUM_EDGES(2)) u2 (
        .CLK(CLK), .RSTN(RSTN), .START(start_i[2]), .SAMPLE_IN(hist[2]), .COUNT_OUT(c2),
        .VALID(valid_o[2]), .ACK(ack_i[2]), .BUSY(busy_o[2]), .OVERFLOW(ovf_o[2]));
    beat_period_counter #(.CNT_W(16), .NUM_EDGES(2)) u3 (
        .CLK(CLK), .RSTN(RSTN), .START(start_i[3]), .SAMPLE_IN(hist[3]), .COUNT_OUT(c3),
        .VALID(valid_o[3]), .ACK(ack_i[3]), .BUSY(busy_o[3]), .OVERFLOW(ovf_o[3]));

    function automatic logic [15:0] get_cnt(int k);
        case (k)
            0:       return c0;
            1:       return c1;
            2:       return {12'd0, c2};
            default: return c3;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: advance every beat generator and shift it into that instance's history
    task automatic step();
        logic bt;
        @(posedge CLK);
        #1;
        for (int k = 0; k < 4; k++) begin
            ph[k] = (ph[k] + 1 >= per[k]) ? 0 : ph[k] + 1;
            bt = (ph[k] < per[k] / 2) || (gl_en[k] && ph[k] == gpos[k]);
            hist[k] = {bt, hist[k][0], hist[k][1]};
        end
    endtask

    task automatic set_period(int k, int p);
        per[k] = p;
        ph[k]  = 0;
        repeat (2 * p) step();
    endtask

    task automatic pulse_start(int k);
        start_i[k] = 1'b1;
        step();
        start_i[k] = 1'b0;
    endtask

    task automatic wait_valid(int k, output bit ok);
        int n = 0;
        while (!valid_o[k] && n < 300) begin
            step();
            n++;
        end
        ok = valid_o[k];
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL valid_timeout inst%0d: VALID got 0 expected 1 within 300 cycles", k);
        end
    endtask

    task automatic pop_cmp(int k);
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("count inst%0d", k), 32'(get_cnt(k)), 32'(e.cnt));
        chk($sformatf("overflow inst%0d", k), 32'(ovf_o[k]), 32'(e.ovf));
        chk($sformatf("busy_in_done inst%0d", k), 32'(busy_o[k]), 32'd0);
    endtask

    task automatic measure(int k, int p, logic [15:0] cnt, logic ovf);
        bit ok;
        set_period(k, p);
        sb.push_back('{k, cnt, ovf});
        pulse_start(k);
        wait_valid(k, ok);
        if (ok) pop_cmp(k);
        else    void'(sb.pop_front());
    endtask

    task automatic do_ack(int k);
        ack_i[k] = 1'b1;
        step();
        ack_i[k] = 1'b0;
        chk($sformatf("valid_after_ack inst%0d", k), 32'(valid_o[k]), 32'd0);
        chk($sformatf("busy_after_ack inst%0d", k), 32'(busy_o[k]), 32'd0);
    endtask

    initial begin
        bit ok;
        vecs[0] = '{0, 8, 16'd32, 1'b0};
        vecs[1] = '{0, 5, 16'd20, 1'b0};
        vecs[2] = '{1, 13, 16'd13, 1'b0};
        vecs[3] = '{1, 4, 16'd4, 1'b0};
        vecs[4] = '{2, 7, 16'd14, 1'b0};
        vecs[5] = '{2, 8, 16'd15, 1'b0};
        vecs[6] = '{2, 9, 16'd15, 1'b1};
        vecs[7] = '{3, 6, 16'd12, 1'b0};

        start_i = 4'd0;
        ack_i   = 4'd0;
        gl_en   = 4'd0;
        for (int k = 0; k < 4; k++) begin
            hist[k] = 3'b000;
            per[k]  = 8;
            ph[k]   = 0;
            gpos[k] = 0;
        end
        RSTN = 1'b0;
        repeat (3) step();
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_overflow", 32'(ovf_o), 32'd0);
        chk("reset_count", 32'(c0 | c1 | c3 | {12'd0, c2}), 32'd0);
        RSTN = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            measure(vecs[i].inst, vecs[i].period, vecs[i].cnt, vecs[i].ovf);
            do_ack(vecs[i].inst);
            chk($sformatf("count_kept_after_ack vec%0d", i), 32'(get_cnt(vecs[i].inst)), 32'(vecs[i].cnt));
        end

        // Result held while ACK stays low
        measure(1, 13, 16'd13, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_valid", 32'(valid_o[1]), 32'd1);
            chk("hold_count", 32'(c1), 32'd13);
        end
        do_ack(1);

        // Single-sample glitch in the low phase of a period-10 beat
        per[3] = 10; ph[3] = 0; gpos[3] = 7; gl_en[3] = 1'b1;
        repeat (20) step();
        pulse_start(3);
        wait_valid(3, ok);
        if (ok) begin
`ifdef BEAT_GLITCH_FILTER_EN
            chk("glitch_filtered_count", 32'(c3), 32'd20);
`else
            checks++;
            if (!(c3 < 16'd20)) begin
                errors++;
                $display("FAIL glitch_counted_count: got %0d required below 20", c3);
            end
`endif
            chk("glitch_overflow", 32'(ovf_o[3]), 32'd0);
        end
        do_ack(3);
        gl_en[3] = 1'b0;

        // One edge then a long high level saturates the 4-bit counter
        per[2] = 100; ph[2] = 80;
        sb.push_back('{2, 16'd15, 1'b1});
        pulse_start(2);
        wait_valid(2, ok);
        if (ok) pop_cmp(2);
        else    void'(sb.pop_front());
        do_ack(2);

        // START held through ACK relaunches; START during COUNT is ignored
        measure(0, 8, 16'd32, 1'b0);
        start_i[0] = 1'b1;
        ack_i[0]   = 1'b1;
        step();
        ack_i[0]   = 1'b0;
        chk("relaunch_valid_drop", 32'(valid_o[0]), 32'd0);
        chk("relaunch_idle_busy", 32'(busy_o[0]), 32'd0);
        step();
        chk("relaunch_arm_busy", 32'(busy_o[0]), 32'd1);
        sb.push_back('{0, 16'd32, 1'b0});
        wait_valid(0, ok);
        if (ok) pop_cmp(0);
        else    void'(sb.pop_front());
        start_i[0] = 1'b0;
        do_ack(0);

        // Reset in the middle of a measurement discards it
        set_period(0, 8);
        pulse_start(0);
        repeat (20) step();
        chk("midcount_busy", 32'(busy_o[0]), 32'd1);
        RSTN = 1'b0;
        #1;
        chk("async_reset_count", 32'(c0), 32'd0);
        chk("async_reset_valid", 32'(valid_o[0]), 32'd0);
        chk("async_reset_busy", 32'(busy_o[0]), 32'd0);
        chk("async_reset_overflow", 32'(ovf_o[0]), 32'd0);
        step();
        step();
        RSTN = 1'b1;
        measure(0, 8, 16'd32, 1'b0);
        do_ack(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beat_period_counter.md
Name: beat_period_counter

Overview:
- Downstream consumer of the 3-bit sampled history produced by the odometer's shift sampler, which samples the beat signal with CLK.
- Detects rising edges of the sampled beat signal and measures the CLK-cycle count spanning NUM_EDGES beat periods.
- The measurement is started on request and returned with a valid/ack handshake to the odometer readout logic.

Parameters:
- CNT_W, 16, width of the cycle counter and COUNT_OUT.
- NUM_EDGES, 4, number of beat periods accumulated per measurement (legal range 1..255).

Ports:
- CLK  input  1  sampling/measurement clock; same clock as the upstream shift sampler.
- RSTN  input  1  asynchronous, active-low reset.
- START  input  1  level; sampled only in IDLE; 1 begins a measurement.
- SAMPLE_IN  input  [0:2]  shift-sampler history; [0] is newest, [2] is oldest.
- COUNT_OUT  output  CNT_W  measured cycle count; held stable while VALID=1.
- VALID  output  1  result available.
- ACK  input  1  consumer accepts the result.
- BUSY  output  1  1 in ARM or COUNT.
- OVERFLOW  output  1  the result saturated; qualified by VALID.

Behaviour:
- Reset (RSTN=0, async):
  - State=IDLE.
  - COUNT_OUT=0, VALID=0, BUSY=0, OVERFLOW=0.
  - Internal counter and edge counter cleared.
  - Applies immediately in any state; a measurement in progress is discarded with no VALID.
- Edge qualifier (combinational): EDGE = SAMPLE_IN[1] & ~SAMPLE_IN[2]. Bit [0] is treated as a metastability settling stage and is not used in the default build.
- FSM states: IDLE, ARM, COUNT, DONE.
- IDLE:
  - START=1 -> ARM next cycle; BUSY=1 from that cycle.
  - SAMPLE_IN is ignored.
- ARM:
  - Waits for the first EDGE.
  - On EDGE: cycle counter <= 0, edge counter <= 0, -> COUNT.
  - No timeout; reset is the only exit without an edge.
- COUNT:
  - Cycle counter increments by 1 every cycle.
  - On EDGE: edge counter increments.
  - When the edge counter reaches NUM_EDGES: COUNT_OUT <= cycle counter + 1, OVERFLOW <= 0, -> DONE.
  - Result: a steady period of P cycles gives COUNT_OUT = P*NUM_EDGES.
- Saturation:
  - If the cycle counter would exceed 2^CNT_W-1 before the final edge: COUNT_OUT <= 2^CNT_W-1, OVERFLOW <= 1, -> DONE.
  - The counter never wraps.
- DONE:
  - VALID=1, BUSY=0. COUNT_OUT and OVERFLOW are held.
  - ACK=1 -> VALID=0 next cycle, -> IDLE.
  - ACK while not VALID is ignored.
- START outside IDLE is ignored, including START and ACK high together in DONE. START must be high in IDLE to launch the next measurement; a continuously high START relaunches one cycle after the return to IDLE.
- COUNT_OUT keeps its last value after ACK until the next measurement completes.
- Latency: VALID rises one cycle after the CLK edge on which the final EDGE is seen.
- Boundary cases:
  - An EDGE on the same cycle as the saturation condition: the edge wins; the measurement completes normally with COUNT_OUT = 2^CNT_W-1 and OVERFLOW=0.
  - An EDGE present in the cycle of the IDLE->ARM transition is not counted.

Optional Feature:
- Macro: BEAT_GLITCH_FILTER_EN.
- Defined: EDGE = SAMPLE_IN[0] & SAMPLE_IN[1] & ~SAMPLE_IN[2]. A high level must persist for two samples to qualify, which rejects single-sample glitches. Latency in cycles is unchanged relative to SAMPLE_IN[1].
- Not defined: the default qualifier described in Behaviour.

Test Plan:
- NUM_EDGES=4, CNT_W=16, beat period 8 cycles, START pulse -> VALID=1 with COUNT_OUT=32, OVERFLOW=0; ACK -> VALID=0 next cycle, state IDLE.
- NUM_EDGES=1, period 13 cycles -> COUNT_OUT=13; hold ACK low for 20 cycles -> COUNT_OUT and VALID stable throughout.
- CNT_W=4, NUM_EDGES=2, one edge then constant high -> COUNT_OUT=15, OVERFLOW=1, VALID=1.
- Drop RSTN low mid-COUNT (after 2 of 4 edges) -> all outputs 0 immediately; a new START with period 8 -> COUNT_OUT=32.
- Single-sample high glitch between valid edges (period 10, NUM_EDGES=2):
  - Macro undefined -> glitch counted, COUNT_OUT < 20.
  - BEAT_GLITCH_FILTER_EN defined -> COUNT_OUT=20.
- START held high with ACK in DONE -> VALID drops, ARM re-entered exactly 2 cycles after ACK; START asserted during COUNT -> no effect on the result.
